uart_tx_ctrl: RTL and testbench

Sequencing controller for the UART transmit shift register. Accepts one byte per valid/ready handshake, computes the parity bit, and generates the shift register's load and shift strobes. It runs a per-bit baud counter and counts bits until the stop bit(s) have been held for a full bit period. It sits between the bus-facing TX data port and `tx_shift_reg`; the shift register's `tx_bit` is the serial line.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/baud_counter.sv | 51 +++++
 rtl/tx_shift_reg.sv | 49 ++++
 rtl/uart_tx.sv | 80 ++++++++
 rtl/uart_tx_ctrl.sv | 144 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 224 ++++++++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, frame constants and parity helper
//
// Purpose : common definitions for the UART TX controller and the RX checker.
// Contents: tx_state_t (IDLE, LOAD, SHIFT), UART_DATA_BITS, UART_BASE_FRAME,
//           parity_calc(data, odd) -> parity bit (even: ^data, odd: ~^data).

package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } tx_state_t;

   localparam int UART_DATA_BITS  = 8;
   // start bit + 8 data bits + one stop bit
   localparam int UART_BASE_FRAME = 10;

   function automatic logic parity_calc(input logic [UART_DATA_BITS-1:0] data,
                                        input logic                      odd);
      return odd ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/baud_counter.sv
// rtl/baud_counter.sv - per-bit baud period counter
//
// Purpose : counts 0..div-1 while enabled and flags the last cycle of a bit.
//           A divisor of 0 behaves as 1 (tick every enabled cycle).
// Ports   : clock, reset_n (async, active low)
//           clear  - force count to 0 (wins over enable)
//           enable - advance the count this cycle
//           div    - clocks per bit
//           count  - current position inside the bit period
//           tick   - enabled and on the last cycle of the bit period

module baud_counter #(
   parameter int DIV_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   output logic [DIV_W-1:0] count,
   output logic             tick
);

   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] last_cnt;

   // div==0 maps to the same terminal count as div==1
   assign last_cnt = (div == '0) ? '0 : div - ONE;
   assign tick     = enable && (cnt_q == last_cnt);
   assign count    = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = tick ? '0 : cnt_q + ONE;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tx_shift_reg.sv
// rtl/tx_shift_reg.sv - UART transmit shift register and serial line flop
//
// Purpose : holds {parity-or-stop, data[7:0], start} and shifts it LSB first
//           onto tx_bit; vacated positions fill with 1 so extra shifts
//           present stop bits.
// Ports   : clock, reset_n (async, active low)
//           load, shift   - strobes from uart_tx_ctrl
//           data, parity_en, parity - frame contents at load
//           tx_bit        - serial line, idles high

module tx_shift_reg (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       load,
   input  logic       shift,
   input  logic [7:0] data,
   input  logic       parity_en,
   input  logic       parity,
   output logic       tx_bit
);

   logic [9:0] sreg_q, sreg_d;
   logic       tx_bit_q, tx_bit_d;

   assign tx_bit = tx_bit_q;

   always_comb begin
      sreg_d   = sreg_q;
      tx_bit_d = tx_bit_q;
      if (load) begin
         // without parity the tenth position is the first stop bit
         sreg_d = {parity_en ? parity : 1'b1, data, 1'b0};
      end else if (shift) begin
         tx_bit_d = sreg_q[0];
         sreg_d   = {1'b1, sreg_q[9:1]};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sreg_q   <= '1;
         tx_bit_q <= 1'b1;
      end else begin
         sreg_q   <= sreg_d;
         tx_bit_q <= tx_bit_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: controller plus shift register
//
// Purpose : joins uart_tx_ctrl and tx_shift_reg into a serial transmitter.
// Ports   : clock, reset_n (async, active low)
//           tx_valid/tx_data/tx_ready - byte handshake
//           parity_en, parity_odd, stop2, baud_div - frame configuration
//           tx_busy, tx_done - status; tx_bit - serial line

module uart_tx #(
   parameter int DIV_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             tx_valid,
   input  logic [7:0]       tx_data,
   output logic             tx_ready,
   input  logic             parity_en,
   input  logic             parity_odd,
   input  logic             stop2,
   input  logic [DIV_W-1:0] baud_div,
   output logic             tx_busy,
   output logic             tx_done,
   output logic             tx_bit
);

   logic       load;
   logic       shift;
   logic       parity;
   logic [7:0] sr_data;
   logic       par_en_q, par_en_d;

   // parity_en is only valid at the handshake, but the load happens a cycle
   // later, so keep our own copy for the shift register
   always_comb begin
      par_en_d = par_en_q;
      if (tx_valid && tx_ready) begin
         par_en_d = parity_en;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         par_en_q <= 1'b0;
      end else begin
         par_en_q <= par_en_d;
      end
   end

   uart_tx_ctrl #(
      .DIV_W (DIV_W)
   ) u_ctrl (
      .clock           (clock),
      .reset_n         (reset_n),
      .tx_valid        (tx_valid),
      .tx_data         (tx_data),
      .tx_ready        (tx_ready),
      .parity_en       (parity_en),
      .parity_odd      (parity_odd),
      .stop2           (stop2),
      .baud_div        (baud_div),
      .tx_shift_reg_en (load),
      .tx_shift_en     (shift),
      .tx_parity_add   (parity),
      .sr_data         (sr_data),
      .tx_busy         (tx_busy),
      .tx_done         (tx_done)
   );

   tx_shift_reg u_sreg (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (load),
      .shift     (shift),
      .data      (sr_data),
      .parity_en (par_en_q),
      .parity    (parity),
      .tx_bit    (tx_bit)
   );

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit sequencing controller
//
// Purpose : accepts a byte per valid/ready handshake, latches the frame
//           configuration, then issues one load strobe and n_bits shift
//           strobes spaced baud_div clocks apart to tx_shift_reg.
// Ports   : clock, reset_n (async, active low)
//           tx_valid/tx_data/tx_ready - byte handshake (ready == IDLE)
//           parity_en, parity_odd, stop2, baud_div - sampled at handshake only
//           tx_shift_reg_en - load strobe (LOAD cycle)
//           tx_shift_en     - shift strobe (first cycle of each bit period)
//           tx_parity_add, sr_data - latched parity bit and byte
//           tx_busy - frame in progress; tx_done - one-cycle completion pulse

module uart_tx_ctrl #(
   parameter int DIV_W = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             tx_valid,
   input  logic [7:0]       tx_data,
   output logic             tx_ready,
   input  logic             parity_en,
   input  logic             parity_odd,
   input  logic             stop2,
   input  logic [DIV_W-1:0] baud_div,
   output logic             tx_shift_reg_en,
   output logic             tx_shift_en,
   output logic             tx_parity_add,
   output logic [7:0]       sr_data,
   output logic             tx_busy,
   output logic             tx_done
);

   import uart_pkg::*;

   tx_state_t                 state_q, state_d;
   logic [UART_DATA_BITS-1:0] data_q, data_d;
   logic                      par_en_q, par_en_d;
   logic                      parity_q, parity_d;
   logic                      stop2_q, stop2_d;
   logic [DIV_W-1:0]          div_q, div_d;
   logic [3:0]                bit_cnt_q, bit_cnt_d;
   logic                      load_q, load_d;
   logic                      done_q, done_d;

   logic [DIV_W-1:0]          baud_cnt;
   logic                      baud_tick;
   logic [3:0]                n_bits;
   logic                      last_bit;

   // Counter runs only in SHIFT; every other state holds it at zero so the
   // first SHIFT cycle always starts a fresh bit period.
   baud_counter #(
      .DIV_W (DIV_W)
   ) u_baud (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (state_q != SHIFT),
      .enable  (state_q == SHIFT),
      .div     (div_q),
      .count   (baud_cnt),
      .tick    (baud_tick)
   );

   assign n_bits   = 4'(UART_BASE_FRAME) + {3'b000, par_en_q} + {3'b000, stop2_q};
   assign last_bit = (bit_cnt_q == n_bits - 4'd1);

   assign tx_ready        = (state_q == IDLE);
   assign tx_busy         = (state_q != IDLE);
   assign tx_shift_en     = (state_q == SHIFT) && (baud_cnt == '0);
   assign tx_shift_reg_en = load_q;
   assign tx_parity_add   = parity_q;
   assign sr_data         = data_q;
   assign tx_done         = done_q;

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      parity_d  = parity_q;
      stop2_d   = stop2_q;
      div_d     = div_q;
      bit_cnt_d = bit_cnt_q;
      load_d    = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               data_d   = tx_data;
               par_en_d = parity_en;
               parity_d = parity_en ? parity_calc(tx_data, parity_odd) : 1'b0;
               stop2_d  = stop2;
               div_d    = baud_div;
               load_d   = 1'b1;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            bit_cnt_d = '0;
            state_d   = SHIFT;
         end
         SHIFT: begin
            if (baud_tick) begin
               if (last_bit) begin
                  bit_cnt_d = '0;
                  done_d    = 1'b1;
                  state_d   = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         parity_q  <= 1'b0;
         stop2_q   <= 1'b0;
         div_q     <= '0;
         bit_cnt_q <= '0;
         load_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         parity_q  <= parity_d;
         stop2_q   <= stop2_d;
         div_q     <= div_d;
         bit_cnt_q <= bit_cnt_d;
         load_q    <= load_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl

module tb_uart_tx_ctrl;

   localparam int DIV_W = 16;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             tx_valid = 1'b0;
   logic [7:0]       tx_data = 8'h00;
   logic             parity_en = 1'b0;
   logic             parity_odd = 1'b0;
   logic             stop2 = 1'b0;
   logic [DIV_W-1:0] baud_div = '0;

   logic             tx_ready;
   logic             tx_shift_reg_en;
   logic             tx_shift_en;
   logic             tx_parity_add;
   logic [7:0]       sr_data;
   logic             tx_busy;
   logic             tx_done;

   int n_vec = 0;
   int n_err = 0;

   // reference serial line built from the strobes the controller emits
   logic [9:0] m_sreg;
   logic       m_line;
   logic       m_pen = 1'b0;

   always #5 clock = ~clock;

   uart_tx_ctrl #(
      .DIV_W (DIV_W)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .tx_valid        (tx_valid),
      .tx_data         (tx_data),
      .tx_ready        (tx_ready),
      .parity_en       (parity_en),
      .parity_odd      (parity_odd),
      .stop2           (stop2),
      .baud_div        (baud_div),
      .tx_shift_reg_en (tx_shift_reg_en),
      .tx_shift_en     (tx_shift_en),
      .tx_parity_add   (tx_parity_add),
      .sr_data         (sr_data),
      .tx_busy         (tx_busy),
      .tx_done         (tx_done)
   );

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_sreg <= '1;
         m_line <= 1'b1;
      end else if (tx_shift_reg_en) begin
         m_sreg <= {m_pen ? tx_parity_add : 1'b1, sr_data, 1'b0};
      end else if (tx_shift_en) begin
         m_line <= m_sreg[0];
         m_sreg <= {1'b1, m_sreg[9:1]};
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Drive the handshake inputs at the current negedge (cycle C0).
   task automatic offer(input logic [7:0] d, input logic pen, input logic podd,
                        input logic s2, input logic [DIV_W-1:0] div);
      tx_valid   = 1'b1;
      tx_data    = d;
      parity_en  = pen;
      parity_odd = podd;
      stop2      = s2;
      baud_div   = div;
      m_pen      = pen;
   endtask

   // Called at the negedge of C0; returns at the negedge of the tx_done cycle.
   // exp_line bit j is the line level expected during bit period j.
   task automatic do_frame(input string tag, input logic [7:0] exp_data,
                           input logic exp_par, input int div_eff, input int nbits,
                           input logic [11:0] exp_line, input bit keep_valid,
                           input bit scramble);
      int   strobes, done_at, gap_err, ready_err, strobe_err, line_err, idx;
      logic line_log [0:511];
      strobes = 0; done_at = -1; gap_err = 0; ready_err = 0; strobe_err = 0; line_err = 0;
      chk({tag, ".ready_c0"}, tx_ready, 1);
      for (int k = 1; k <= 400 && done_at < 0; k++) begin
         @(negedge clock);
         if (k == 1) begin
            chk({tag, ".load_c1"}, tx_shift_reg_en, 1);
            chk({tag, ".sr_data"}, sr_data, exp_data);
            chk({tag, ".parity"}, tx_parity_add, exp_par);
            chk({tag, ".busy_c1"}, tx_busy, 1);
            chk({tag, ".ready_c1"}, tx_ready, 0);
            if (!keep_valid) begin
               tx_valid = 1'b0;
               tx_data  = ~tx_data;
            end
         end
         if (scramble && k == 3) begin
            parity_en  = ~parity_en;
            parity_odd = ~parity_odd;
            stop2      = ~stop2;
            baud_div   = baud_div + 16'd7;
            tx_data    = 8'hFF;
         end
         line_log[k] = m_line;
         if (tx_shift_en) begin
            if (k != 2 + strobes * div_eff) gap_err++;
            strobes++;
         end
         if (tx_shift_en && tx_shift_reg_en) strobe_err++;
         if (k > 1 && tx_shift_reg_en) strobe_err++;
         if (tx_done) done_at = k;
         else if (tx_ready) ready_err++;
      end
      chk({tag, ".strobes"}, strobes, nbits);
      chk({tag, ".done_cycle"}, done_at, 2 + nbits * div_eff);
      chk({tag, ".strobe_spacing"}, gap_err, 0);
      chk({tag, ".ready_low_in_frame"}, ready_err, 0);
      chk({tag, ".strobe_exclusive"}, strobe_err, 0);
      chk({tag, ".ready_at_done"}, tx_ready, 1);
      chk({tag, ".busy_at_done"}, tx_busy, 0);
      for (int j = 0; j < nbits; j++) begin
         for (int m = 0; m < div_eff; m++) begin
            idx = 3 + j * div_eff + m;
            if (idx > 400 || line_log[idx] !== exp_line[j]) line_err++;
         end
      end
      chk({tag, ".line_bits"}, line_err, 0);
   endtask

   initial begin
      int strobes;

      // reset state
      repeat (2) @(negedge clock);
      chk("rst.busy", tx_busy, 0);
      chk("rst.done", tx_done, 0);
      chk("rst.shift_en", tx_shift_en, 0);
      chk("rst.load_en", tx_shift_reg_en, 0);
      chk("rst.parity", tx_parity_add, 0);
      chk("rst.sr_data", sr_data, 8'h00);
      reset_n = 1'b1;
      @(negedge clock);
      chk("rst.ready", tx_ready, 1);

      // 0xA5, div 4, no parity, 1 stop: line 0,1,0,1,0,0,1,0,1,1
      offer(8'hA5, 1'b0, 1'b0, 1'b0, 16'd4);
      do_frame("a5", 8'hA5, 1'b0, 4, 10, 12'hF4A, 1'b0, 1'b0);
      repeat (2) @(negedge clock);

      // 0x07 even parity -> 1
      offer(8'h07, 1'b1, 1'b0, 1'b0, 16'd3);
      do_frame("p_even", 8'h07, 1'b1, 3, 11, 12'hE0E, 1'b0, 1'b0);
      @(negedge clock);

      // 0x07 odd parity -> 0
      offer(8'h07, 1'b1, 1'b1, 1'b0, 16'd3);
      do_frame("p_odd", 8'h07, 1'b0, 3, 11, 12'hC0E, 1'b0, 1'b0);
      @(negedge clock);

      // 0x3C, even parity (0), two stops, div 0 treated as 1
      offer(8'h3C, 1'b1, 1'b0, 1'b1, 16'd0);
      do_frame("s2_div0", 8'h3C, 1'b0, 1, 12, 12'hC78, 1'b0, 1'b0);
      @(negedge clock);

      // back-to-back with tx_valid held high
      offer(8'h55, 1'b0, 1'b0, 1'b0, 16'd2);
      do_frame("b2b_1", 8'h55, 1'b0, 2, 10, 12'hEAA, 1'b1, 1'b0);
      tx_data = 8'hAA;
      do_frame("b2b_2", 8'hAA, 1'b0, 2, 10, 12'hF54, 1'b0, 1'b0);
      @(negedge clock);

      // configuration changed mid-frame must not affect the frame
      offer(8'h07, 1'b1, 1'b0, 1'b0, 16'd2);
      do_frame("cfg_chg", 8'h07, 1'b1, 2, 11, 12'hE0E, 1'b0, 1'b1);
      @(negedge clock);

      // reset asserted during bit 5 (strobe at C17 with div 3)
      offer(8'h33, 1'b0, 1'b0, 1'b0, 16'd3);
      strobes = 0;
      for (int k = 1; k <= 17; k++) begin
         @(negedge clock);
         if (k == 1) tx_valid = 1'b0;
         if (tx_shift_en) strobes++;
      end
      chk("mid.strobes_before_rst", strobes, 6);
      #2 reset_n = 1'b0;
      #1;
      chk("mid.busy", tx_busy, 0);
      chk("mid.shift_en", tx_shift_en, 0);
      chk("mid.load_en", tx_shift_reg_en, 0);
      chk("mid.sr_data", sr_data, 8'h00);
      chk("mid.parity", tx_parity_add, 0);
      chk("mid.done", tx_done, 0);
      strobes = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         if (tx_shift_en || tx_shift_reg_en || tx_done) strobes++;
      end
      chk("mid.quiet_in_rst", strobes, 0);
      reset_n = 1'b1;
      @(negedge clock);
      chk("mid.ready_after", tx_ready, 1);
      chk("mid.line_idle", m_line, 1);
      offer(8'h07, 1'b1, 1'b1, 1'b0, 16'd1);
      do_frame("post_rst", 8'h07, 1'b0, 1, 11, 12'hC0E, 1'b0, 1'b0);
      repeat (2) @(negedge clock);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
